// File: rtl/rtf65002_icachectrl.sv
// rtf65002 instruction cache controller: miss detection, 4-beat
// WISHBONE line refill and whole-cache invalidate sweep.
module rtf65002_icachectrl #(
  parameter int LINES  = 256,
  parameter int SETTLE = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ic_en_i,
  input  logic        inv_i,
  input  logic        fetch_i,
  input  logic [31:0] pc_i,
  input  logic        hit0_i,
  input  logic        hit1_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [2:0]  cti_o,
  output logic [1:0]  bte_o,
  output logic [33:0] adr_o,
  input  logic        ack_i,
  input  logic        err_i,
  output logic        dat_wr_o,
  output logic        tag_wr_o,
  output logic [33:0] tag_adr_o,
  output logic        fill_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FILL, S_SETTLE, S_INV
  } st_t;

  st_t         state, nstate;
  logic [31:0] pc_q;
  logic        pcstable;
  logic        inv_pend;
  logic [27:0] line_q;
  logic [1:0]  cnt_q;
  logic [7:0]  idx_q;
  logic [7:0]  scnt_q;
  logic        miss0, miss1;
  logic [27:0] line_nxt;

  assign miss0 = ic_en_i & fetch_i & pcstable & ~hit0_i;
  assign miss1 = ic_en_i & fetch_i & pcstable & ~hit1_i;
  // line index of pc+8: carry out of bit 3 into the line field
  assign line_nxt = pc_i[31:4] + {27'd0, pc_i[3]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= nstate;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= '0;
      pcstable <= 1'b0;
      inv_pend <= 1'b0;
      line_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      scnt_q   <= '0;
    end else begin
      pc_q     <= pc_i;
      pcstable <= (pc_i == pc_q);
      if (inv_i)
        inv_pend <= 1'b1;
      else if (state == S_IDLE && inv_pend)
        inv_pend <= 1'b0;
      if (state == S_IDLE && !inv_pend) begin
        if (miss0)      line_q <= pc_i[31:4];
        else if (miss1) line_q <= line_nxt;
      end
      if (state == S_CLR)
        cnt_q <= '0;
      else if (state == S_FILL && ack_i && !err_i)
        cnt_q <= cnt_q + 2'd1;
      idx_q  <= (state == S_INV) ? idx_q + 8'd1 : 8'd0;
      scnt_q <= (state == S_SETTLE) ? scnt_q + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          inv_pend:      nstate = S_INV;
          miss0 | miss1: nstate = S_CLR;
          default:       nstate = S_IDLE;
        endcase
      end
      S_CLR:  nstate = S_FILL;
      S_FILL: begin
        if (err_i)
          nstate = S_SETTLE;
        else if (ack_i && cnt_q == 2'd3)
          nstate = S_SETTLE;
      end
      S_SETTLE: begin
        if (scnt_q == 8'(SETTLE - 1))
          nstate = S_IDLE;
      end
      S_INV: begin
        if (idx_q == 8'(LINES - 1))
          nstate = S_SETTLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    cyc_o      = 1'b0;
    stb_o      = 1'b0;
    cti_o      = 3'b000;
    bte_o      = 2'b00;
    adr_o      = '0;
    dat_wr_o   = 1'b0;
    tag_wr_o   = 1'b0;
    tag_adr_o  = '0;
    fill_err_o = 1'b0;
    unique case (state)
      S_CLR: begin
        tag_wr_o  = 1'b1;
        tag_adr_o = {2'b00, line_q, 2'b11, 2'b00};
      end
      S_FILL: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        adr_o = {2'b00, line_q, cnt_q, 2'b00};
        cti_o = (cnt_q == 2'd3) ? 3'b111 : 3'b010;
        // tag RAM keeps only the cnt=3 write, which marks the line valid
        if (err_i) begin
          fill_err_o = 1'b1;
        end else if (ack_i) begin
          dat_wr_o  = 1'b1;
          tag_wr_o  = 1'b1;
          tag_adr_o = {2'b00, line_q, cnt_q, 2'b01};
        end
      end
      S_INV: begin
        tag_wr_o  = 1'b1;
        tag_adr_o = {22'h0, idx_q, 2'b11, 2'b00};
      end
      default: ;
    endcase
  end

  assign busy_o  = (state != S_IDLE);
  assign ready_o = (state == S_IDLE) & ic_en_i & pcstable
                 & hit0_i & hit1_i;

endmodule

// File: tb/tb_rtf65002_icachectrl.sv
// Directed bench for rtf65002_icachectrl: fills, bus error,
// invalidate sweeps and asynchronous reset mid-burst.
module tb_rtf65002_icachectrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ic_en_i, inv_i, fetch_i;
  logic [31:0] pc_i;
  logic        hit0_i, hit1_i;
  logic        ready_o, busy_o, cyc_o, stb_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic [33:0] adr_o;
  logic        ack_i, err_i;
  logic        dat_wr_o, tag_wr_o;
  logic [33:0] tag_adr_o;
  logic        fill_err_o;

  int vectors = 0;
  int miscompares = 0;

  rtf65002_icachectrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ic_en_i(ic_en_i),
    .inv_i(inv_i), .fetch_i(fetch_i), .pc_i(pc_i),
    .hit0_i(hit0_i), .hit1_i(hit1_i), .ready_o(ready_o),
    .busy_o(busy_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .cti_o(cti_o), .bte_o(bte_o), .adr_o(adr_o),
    .ack_i(ack_i), .err_i(err_i), .dat_wr_o(dat_wr_o),
    .tag_wr_o(tag_wr_o), .tag_adr_o(tag_adr_o),
    .fill_err_o(fill_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string tag, logic [33:0] obs,
                     logic [33:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic wait_tagwr(string tag);
    int n = 0;
    while (tag_wr_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, {33'd0, tag_wr_o}, 34'd1);
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (busy_o !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    chk(tag, {33'd0, busy_o}, 34'd0);
  endtask

  task automatic setup_pc(logic [31:0] p, logic h0, logic h1);
    fetch_i = 1'b0;
    pc_i    = p;
    hit0_i  = h0;
    hit1_i  = h1;
    repeat (3) step();
    fetch_i = 1'b1;
  endtask

  // one acked beat i of a line at byte address base
  task automatic beat(int i, logic [33:0] base);
    logic [33:0] a;
    a = base + 34'(4 * i);
    ack_i = 1'b1;
    #1;
    chk("adr", adr_o, a);
    chk("cti", {31'd0, cti_o}, (i < 3) ? 34'd2 : 34'd7);
    chk("dat_wr", {33'd0, dat_wr_o}, 34'd1);
    chk("tag_adr_beat", tag_adr_o, a | 34'd1);
    step();
    ack_i = 1'b0;
  endtask

  initial begin
    rst_ni  = 1'b1;
    ic_en_i = 1'b1;
    inv_i   = 1'b0;
    fetch_i = 1'b0;
    pc_i    = '0;
    hit0_i  = 1'b1;
    hit1_i  = 1'b1;
    ack_i   = 1'b0;
    err_i   = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_busy", {33'd0, busy_o}, 34'd0);
    chk("rst_cyc", {33'd0, cyc_o}, 34'd0);
    chk("rst_tag_wr", {33'd0, tag_wr_o}, 34'd0);
    chk("rst_ready", {33'd0, ready_o}, 34'd0);
    step();
    step();
    rst_ni = 1'b1;

    // current-line miss at 0x1234
    setup_pc(32'h0000_1234, 1'b0, 1'b0);
    wait_tagwr("clr1");
    chk("clr1_adr", tag_adr_o, 34'h123C);
    step();
    chk("fill1_cyc", {33'd0, cyc_o}, 34'd1);
    chk("fill1_bte", {32'd0, bte_o}, 34'd0);
    chk("fill1_wait_dat", {33'd0, dat_wr_o}, 34'd0);
    for (int i = 0; i < 4; i++) beat(i, 34'h1230);
    hit0_i = 1'b1;
    hit1_i = 1'b1;
    #1;
    chk("fill1_cyc_drop", {33'd0, cyc_o}, 34'd0);
    chk("fill1_busy_s0", {33'd0, busy_o}, 34'd1);
    step();
    chk("fill1_busy_s1", {33'd0, busy_o}, 34'd1);
    step();
    chk("fill1_idle", {33'd0, busy_o}, 34'd0);
    chk("fill1_ready", {33'd0, ready_o}, 34'd1);

    // next-line miss, pc+8 crosses into line 0x210
    setup_pc(32'h0000_20FC, 1'b1, 1'b0);
    wait_tagwr("clr2");
    chk("clr2_adr", tag_adr_o, 34'h210C);
    step();
    for (int i = 0; i < 4; i++) beat(i, 34'h2100);
    hit1_i = 1'b1;
    wait_idle("fill2_idle");
    #1;
    chk("fill2_ready", {33'd0, ready_o}, 34'd1);

    // bus error on beat 1
    setup_pc(32'h0000_3000, 1'b0, 1'b1);
    wait_tagwr("clr3");
    step();
    beat(0, 34'h3000);
    ack_i = 1'b1;
    err_i = 1'b1;
    #1;
    chk("err_pulse", {33'd0, fill_err_o}, 34'd1);
    chk("err_tag_wr", {33'd0, tag_wr_o}, 34'd0);
    chk("err_dat_wr", {33'd0, dat_wr_o}, 34'd0);
    step();
    ack_i   = 1'b0;
    err_i   = 1'b0;
    fetch_i = 1'b0;
    #1;
    chk("err_cyc_drop", {33'd0, cyc_o}, 34'd0);
    chk("err_one_pulse", {33'd0, fill_err_o}, 34'd0);
    wait_idle("err_idle");

    // cache disabled: a miss starts nothing
    ic_en_i = 1'b0;
    setup_pc(32'h0000_6000, 1'b0, 1'b0);
    repeat (4) step();
    chk("dis_busy", {33'd0, busy_o}, 34'd0);
    fetch_i = 1'b0;
    ic_en_i = 1'b1;

    // invalidate sweep from idle
    inv_i = 1'b1;
    step();
    inv_i = 1'b0;
    wait_tagwr("inv_start");
    for (int i = 0; i < 256; i++) begin
      chk("inv_wr", {33'd0, tag_wr_o}, 34'd1);
      chk("inv_adr", tag_adr_o, {22'd0, 8'(i), 4'hC});
      step();
    end
    chk("inv_end_wr", {33'd0, tag_wr_o}, 34'd0);
    wait_idle("inv_idle");

    // invalidate requested during beat 2 of a fill
    setup_pc(32'h0000_4000, 1'b0, 1'b1);
    wait_tagwr("clr5");
    step();
    beat(0, 34'h4000);
    beat(1, 34'h4000);
    inv_i = 1'b1;
    beat(2, 34'h4000);
    inv_i = 1'b0;
    beat(3, 34'h4000);
    hit0_i  = 1'b1;
    fetch_i = 1'b0;
    wait_tagwr("inv5_start");
    chk("inv5_adr0", tag_adr_o, 34'h0000C);
    repeat (256) step();
    wait_idle("inv5_idle");

    // asynchronous reset during beat 1 with stalls
    setup_pc(32'h0000_5000, 1'b0, 1'b1);
    wait_tagwr("clr6");
    step();
    repeat ($urandom_range(0, 3)) step();
    beat(0, 34'h5000);
    repeat ($urandom_range(1, 3)) step();
    chk("stall_cyc", {33'd0, cyc_o}, 34'd1);
    ack_i = 1'b1;
    #1;
    chk("pre_rst_dat", {33'd0, dat_wr_o}, 34'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_cyc", {33'd0, cyc_o}, 34'd0);
    chk("arst_stb", {33'd0, stb_o}, 34'd0);
    chk("arst_tag_wr", {33'd0, tag_wr_o}, 34'd0);
    chk("arst_dat_wr", {33'd0, dat_wr_o}, 34'd0);
    step();
    ack_i   = 1'b0;
    fetch_i = 1'b0;
    rst_ni  = 1'b1;
    step();
    chk("post_rst_busy", {33'd0, busy_o}, 34'd0);
    step();
    chk("post_rst_idle", {33'd0, busy_o}, 34'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rtf65002_icachectrl.md
Name:
rtf65002_icachectrl

Overview:
Sequences the 4K instruction-cache tag RAM and its data RAM. Detects misses on the current line (hit0) and the next line (pc+8, hit1), then runs a 4-beat WISHBONE burst to refill the line. The tag is invalidated before the burst and committed as valid on the final beat. Also performs a whole-cache invalidate sweep on request. Sits between the core fetch unit, the tag/data RAMs and the bus interface.

Parameters:
LINES, 256, number of cache lines; the sweep index is 8 bits wide.
SETTLE, 2, idle cycles after any tag write before hits are re-evaluated (write commit plus registered read).

Ports:
clk_i  in  1  single clock; also drives the tag RAM wclk and rclk.
rst_ni  in  1  asynchronous active-low reset.
ic_en_i  in  1  cache enable; when low, no fills are started.
inv_i  in  1  one-cycle pulse requesting invalidation of every line.
fetch_i  in  1  core requests instruction bytes at pc_i.
pc_i  in  32  fetch address.
hit0_i  in  1  tag hit for line of registered pc.
hit1_i  in  1  tag hit for line of registered pc+8.
ready_o  out  1  both lines present; the fetch may proceed.
busy_o  out  1  controller not in IDLE.
cyc_o  out  1  WISHBONE cycle.
stb_o  out  1  WISHBONE strobe.
cti_o  out  3  cycle type: 010 incrementing, 111 end of burst.
bte_o  out  2  burst type; always 00.
adr_o  out  34  bus byte address.
ack_i  in  1  bus acknowledge.
err_i  in  1  bus error.
dat_wr_o  out  1  data RAM write strobe, one per acked beat.
tag_wr_o  out  1  tag RAM write enable.
tag_adr_o  out  34  tag RAM write address/data. Bits [3:2] select the commit beat; bit 0 is the valid bit.
fill_err_o  out  1  one-cycle pulse when a fill is aborted.

Behaviour:
- Reset (async, rst_ni=0): state IDLE; counters, line register and inv_pend cleared. Every output is 0, including cyc_o and stb_o, which drop immediately even mid-burst.
- pcstable is a register: pc_i equals pc_i of the previous cycle. Hits are trusted only when pcstable=1 and the controller is in IDLE.
- ready_o = IDLE & ic_en_i & pcstable & hit0_i & hit1_i.
- busy_o = (state != IDLE).
- States: IDLE, CLR, FILL, SETTLE, INV.
- IDLE priority order:
  - inv_pend set -> INV, idx=0.
  - Else if ic_en_i & fetch_i & pcstable & !hit0_i -> line=pc_i[31:4] -> CLR.
  - Else if the same conditions hold & !hit1_i -> line=(pc_i+8)[31:4] -> CLR. pc+8 is a 32-bit add that wraps at 2^32.
- CLR (1 cycle):
  - tag_wr_o=1, tag_adr_o={2'b00,line,2'b11,2'b00}, i.e. an invalid tag.
  - Then go to FILL with cnt=0.
- FILL:
  - cyc_o=stb_o=1, bte_o=00, adr_o={2'b00,line,cnt,2'b00}.
  - cti_o=010 while cnt<3; cti_o=111 at cnt=3.
  - On ack_i, for that cycle: dat_wr_o=1, tag_wr_o=1, tag_adr_o={2'b00,line,cnt,2'b01}. The tag RAM commits only the cnt=3 write, which sets valid. Then cnt++.
  - On ack_i at cnt=3: cyc_o and stb_o are 0 on the next cycle; go to SETTLE.
  - err_i (takes precedence over a simultaneous ack_i): no dat_wr_o, no tag_wr_o, fill_err_o=1 for one cycle, cyc_o and stb_o drop next cycle -> SETTLE. The line stays invalid.
  - Wait states, i.e. no ack: all outputs held.
- SETTLE: counts SETTLE cycles, then IDLE. No bus or tag activity.
- INV:
  - One line per cycle: tag_wr_o=1, tag_adr_o={22'h0,idx[7:0],2'b11,2'b00}.
  - After idx=LINES-1 (256 cycles) -> SETTLE. inv_pend is cleared on entry to INV.
- inv_i at any time sets inv_pend. It is serviced at the next IDLE, so a fill in progress always completes first. inv_i during INV re-arms inv_pend, giving one further sweep.
- ic_en_i dropping mid-fill does not abort the fill.

Test Plan:
- After reset: pc_i=0x0000_1234 held, fetch_i=1, hit0_i=0 -> CLR writes tag_adr_o=0x0000_123C. Beats at adr_o=0x1230, 0x1234, 0x1238, 0x123C, with cti_o=010,010,010,111. The last tag_adr_o is 0x0000_123D. Then busy_o falls 2 cycles after the final ack.
- pc_i=0x0000_20FC, hit0_i=1, hit1_i=0 -> fill of line 0x0000_2100. With both hits driven high afterwards, ready_o=1.
- err_i on beat 1 of a fill -> exactly one fill_err_o pulse, no tag_wr_o with bit0=1, cyc_o low on the next cycle, return to IDLE.
- inv_i pulse while idle -> 256 consecutive tag_wr_o cycles, tag_adr_o[11:4] running 00..FF with bit0=0, then IDLE.
- inv_i during beat 2 of a fill -> the fill completes normally, then the sweep starts.
- rst_ni low during beat 1 with random ack stalls -> cyc_o, stb_o, tag_wr_o and dat_wr_o go to 0 asynchronously. After release the controller is in IDLE and busy_o=0.
